// File: rtl/spi_flash_read_arbiter.sv
// spi_flash_read_arbiter: wakes the AT25SF081 from deep power-down, then serves round-robin
// 32-bit little-endian reads (cmd 0x03) for two requesters over a mode-0 SPI bit engine.
module spi_flash_read_arbiter #(
    parameter int CLK_DIV        = 2,
    parameter int WAKE_CYCLES    = 48,
    parameter int CS_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [23:0] req0_addr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [23:0] req1_addr,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);
    typedef enum logic [2:0] {WAKE_CMD, WAKE_WAIT, IDLE, CMD, ADDR, DATA, GAP} state_t;

    state_t      state;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic [5:0]  bit_cnt;
    logic [15:0] div_cnt;
    logic [15:0] cnt;
    logic        cur_id;
    logic        last_grant;
    logic        half_done;
    logic        pick1;

    assign half_done = div_cnt == 16'(CLK_DIV - 1);
    assign pick1     = req1_valid && (!req0_valid || !last_grant);
    assign busy      = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAKE_CMD;
            flash_csb  <= 1'b1;
            flash_clk  <= 1'b0;
            flash_io0  <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            cnt        <= '0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rsp_valid  <= 1'b0;
            case (state)
                WAKE_WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == 16'(WAKE_CYCLES - 1)) state <= IDLE;
                end
                IDLE: if (req0_valid || req1_valid) begin
                    req0_ready           <= !pick1;
                    req1_ready           <= pick1;
                    cur_id               <= pick1;
                    last_grant           <= pick1;
                    flash_csb            <= 1'b0;
                    flash_clk            <= 1'b0;
                    {flash_io0, tx_sr}   <= {8'h03, pick1 ? req1_addr : req0_addr, 1'b0};
                    bit_cnt              <= '0;
                    div_cnt              <= '0;
                    state                <= CMD;
                end
                GAP: begin
                    rsp_valid <= cnt == 16'd0;
                    if (cnt == 16'd0) begin
                        rsp_data <= rx_sr;
                        rsp_id   <= cur_id;
                    end
                    cnt <= cnt + 16'd1;
                    if (cnt == 16'(CS_HIGH_CYCLES)) state <= IDLE;
                end
                default: begin
                    // csb still high in WAKE_CMD means the wake command has not started yet
                    if (state == WAKE_CMD && flash_csb) begin
                        flash_csb          <= 1'b0;
                        {flash_io0, tx_sr} <= {8'hAB, 25'd0};
                        bit_cnt            <= '0;
                        div_cnt            <= '0;
                    end else if (!half_done) begin
                        div_cnt <= div_cnt + 16'd1;
                    end else begin
                        div_cnt   <= '0;
                        flash_clk <= !flash_clk;
                        if (!flash_clk) begin
                            if (state == DATA) rx_sr[{bit_cnt[4:3], ~bit_cnt[2:0]}] <= flash_io1;
                        end else begin
                            bit_cnt            <= bit_cnt + 6'd1;
                            {flash_io0, tx_sr} <= {tx_sr, 1'b0};
                            if (state == WAKE_CMD && bit_cnt == 6'd7) begin
                                flash_csb <= 1'b1;
                                cnt       <= '0;
                                state     <= WAKE_WAIT;
                            end else if (bit_cnt == 6'd7) begin
                                state <= ADDR;
                            end else if (bit_cnt == 6'd31) begin
                                state <= DATA;
                            end else if (bit_cnt == 6'd63) begin
                                flash_csb <= 1'b1;
                                cnt       <= '0;
                                state     <= GAP;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_read_arbiter.sv
// tb_spi_flash_read_arbiter: directed bench with a behavioural flash model; instance 0 uses
// CLK_DIV=2, instance 1 uses CLK_DIV=1.
module tb_spi_flash_read_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  r0v, r1v, rdy0, rdy1, rv, rid, bsy, csb, sck, mosi;
    logic [23:0] r0a [2];
    logic [23:0] r1a [2];
    logic [31:0] rd  [2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h100000: return 8'h11;
            24'h100001: return 8'h22;
            24'h100002: return 8'h33;
            24'h100003: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : fm
        logic        miso = 1'b0;
        logic        pc = 1'b1, pk = 1'b0, pks = 1'b0;
        logic [63:0] sr = '0, last_sr = '0;
        logic [23:0] fa = '0;
        logic [7:0]  b;
        logic [7:0]  gnt_seq = '0, id_seq = '0;
        int          nbits = 0, last_bits = 0, j;
        int          rsp_cnt = 0, gnt_cnt = 0, gnt_cyc = 0, lat = 0, sck_last = 0, sck_per = 0;

        spi_flash_read_arbiter #(.CLK_DIV(g == 0 ? 2 : 1)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(r0v[g]), .req0_addr(r0a[g]), .req0_ready(rdy0[g]),
            .req1_valid(r1v[g]), .req1_addr(r1a[g]), .req1_ready(rdy1[g]),
            .rsp_valid(rv[g]), .rsp_id(rid[g]), .rsp_data(rd[g]), .busy(bsy[g]),
            .flash_csb(csb[g]), .flash_clk(sck[g]), .flash_io0(mosi[g]), .flash_io1(miso)
        );

        // flash: samples MOSI on SCK rise, shifts read data out on SCK fall after the address
        always @(csb[g] or sck[g]) begin
            if (csb[g] && !pc) begin
                last_bits = nbits;
                last_sr   = sr;
            end
            if (!csb[g] && pc) begin
                nbits = 0;
                sr    = '0;
                miso  = 1'b0;
            end else if (!csb[g] && sck[g] && !pk) begin
                sr = {sr[62:0], mosi[g]};
                nbits++;
                if (nbits == 32) fa = sr[23:0];
            end else if (!csb[g] && !sck[g] && pk && nbits >= 32 && nbits < 64) begin
                j    = nbits - 32;
                b    = fbyte(fa + 24'(j / 8));
                miso = b[7 - j % 8];
            end
            pc = csb[g];
            pk = sck[g];
        end

        always @(negedge clk) begin
            if (rdy0[g] || rdy1[g]) begin
                gnt_seq = {gnt_seq[6:0], rdy1[g]};
                gnt_cnt++;
                gnt_cyc = cyc;
            end
            if (rv[g]) begin
                id_seq = {id_seq[6:0], rid[g]};
                rsp_cnt++;
                lat = cyc - gnt_cyc;
            end
            if (sck[g] && !pks) begin
                sck_per  = cyc - sck_last;
                sck_last = cyc;
            end
            pks = sck[g];
        end
    end

    function automatic int rcnt(input int g);
        return g == 0 ? fm[0].rsp_cnt : fm[1].rsp_cnt;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input int g, input logic who, input logic [23:0] a, input int exp_lat, input string tag);
        int n, t;
        n = rcnt(g);
        if (who) begin r1a[g] = a; r1v[g] = 1'b1; end
        else     begin r0a[g] = a; r0v[g] = 1'b1; end
        t = 0;
        while (!(who ? rdy1[g] : rdy0[g]) && t < 2000) begin tick(); t++; end
        chk({tag, " grant"}, 32'(t < 2000), 32'd1);
        if (who) r1v[g] = 1'b0; else r0v[g] = 1'b0;
        t = 0;
        while (rcnt(g) == n && t < 2000) begin tick(); t++; end
        chk({tag, " rsp"}, 32'(t < 2000), 32'd1);
        chk({tag, " id"}, 32'(rid[g]), 32'(who));
        chk({tag, " data"}, rd[g], exp_word(a));
        chk({tag, " lat"}, g == 0 ? fm[0].lat : fm[1].lat, exp_lat);
    endtask

    task automatic wake_check(input string tag);
        int  t, hi;
        logic lo, early;
        t = 0; hi = 0; lo = 1'b0; early = 1'b0;
        while (bsy[0] && t < 3000) begin
            tick();
            t++;
            if (!csb[0]) lo = 1'b1;
            else if (lo && bsy[0]) hi++;
            if (rdy0[0] && bsy[0]) early = 1'b1;
        end
        chk({tag, " idle"}, 32'(t < 3000), 32'd1);
        chk({tag, " wake bits"}, fm[0].last_bits, 32'd8);
        chk({tag, " wake byte"}, 32'(fm[0].last_sr[7:0]), 32'h0000_00AB);
        chk({tag, " csb high"}, hi, 32'd48);
        chk({tag, " early ready"}, 32'(early), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t, n, ng, k, run, minrun;
        logic        started;
        logic [31:0] dl [4];
        r0v = '0; r1v = '0;
        r0a[0] = '0; r0a[1] = '0; r1a[0] = '0; r1a[1] = '0;
        repeat (3) tick();
        chk("rst csb", 32'(csb[0]), 32'd1);
        chk("rst sck", 32'(sck[0]), 32'd0);
        chk("rst io0", 32'(mosi[0]), 32'd0);
        chk("rst rdy0", 32'(rdy0[0]), 32'd0);
        chk("rst rdy1", 32'(rdy1[0]), 32'd0);
        chk("rst rsp_valid", 32'(rv[0]), 32'd0);
        chk("rst rsp_id", 32'(rid[0]), 32'd0);
        chk("rst rsp_data", rd[0], 32'd0);
        chk("rst busy", 32'(bsy[0]), 32'd1);

        r0a[0] = 24'h100000;
        r0v[0] = 1'b1;
        rst = 1'b0;
        wake_check("wake");
        do_read(0, 1'b0, 24'h100000, 257, "rd0");
        chk("rd0 word", rd[0], 32'h4433_2211);
        chk("rd0 mosi", fm[0].last_sr[63:32], 32'h0310_0000);
        chk("rd0 bits", fm[0].last_bits, 32'd64);
        chk("rd0 grants", fm[0].gnt_cnt, 32'd1);
        chk("rd0 rsp count", fm[0].rsp_cnt, 32'd1);

        do_read(0, 1'b1, 24'h000020, 257, "r1a");
        do_read(0, 1'b1, 24'h000444, 257, "r1b");
        do_read(0, 1'b1, 24'hFFFFFC, 257, "r1c");
        chk("r1 only grants", 32'(fm[0].gnt_seq[2:0]), 32'b111);

        n = fm[0].rsp_cnt; ng = 0; k = 0; run = 0; minrun = 1000; started = 1'b0;
        r0a[0] = 24'h000100; r1a[0] = 24'h00ABC0;
        r0v[0] = 1'b1; r1v[0] = 1'b1;
        t = 0;
        while (fm[0].rsp_cnt < n + 4 && t < 5000) begin
            tick();
            t++;
            if (rdy0[0] || rdy1[0]) begin
                ng++;
                if (ng == 4) begin r0v[0] = 1'b0; r1v[0] = 1'b0; end
            end
            if (rv[0] && k < 4) begin dl[k] = rd[0]; k++; end
            if (csb[0]) run++;
            else begin
                if (started && run > 0 && run < minrun) minrun = run;
                started = 1'b1;
                run = 0;
            end
        end
        chk("tie done", 32'(t < 5000), 32'd1);
        chk("tie grant order", 32'(fm[0].gnt_seq[3:0]), 32'b0101);
        chk("tie rsp ids", 32'(fm[0].id_seq[3:0]), 32'b0101);
        chk("tie csb gap", 32'(minrun >= 2), 32'd1);
        for (int i = 0; i < 4; i++)
            chk("tie data", dl[i], exp_word(i % 2 == 1 ? 24'h00ABC0 : 24'h000100));

        n = fm[0].rsp_cnt;
        r0a[0] = 24'h0ABCDE;
        r0v[0] = 1'b1;
        t = 0;
        while (!rdy0[0] && t < 2000) begin tick(); t++; end
        chk("abort grant", 32'(t < 2000), 32'd1);
        r0v[0] = 1'b0;
        repeat (40) tick();
        chk("abort in addr", 32'(csb[0] == 1'b0 && fm[0].nbits > 8 && fm[0].nbits < 32), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("abort csb", 32'(csb[0]), 32'd1);
        chk("abort sck", 32'(sck[0]), 32'd0);
        chk("abort rsp_data", rd[0], 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        wake_check("rewake");
        chk("abort no rsp", fm[0].rsp_cnt, n);
        do_read(0, 1'b0, 24'h123456, 257, "post");

        t = 0;
        while (bsy[1] && t < 2000) begin tick(); t++; end
        chk("div1 idle", 32'(t < 2000), 32'd1);
        do_read(1, 1'b0, 24'h0000FC, 129, "div1");
        chk("div1 word", rd[1], 32'hA5A4_A7A6);
        chk("div1 sck period", fm[1].sck_per, 32'd2);
        repeat (10) tick();
        chk("div1 hold", rd[1], 32'hA5A4_A7A6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_flash_read_arbiter.md
Name: spi_flash_read_arbiter

Overview:
Sequences single-bit SPI reads (cmd 0x03) from the onboard AT25SF081 flash and shares that flash between two requesters, e.g. a boot loader and a debug/config master. After reset it issues Release-from-Deep-Power-Down (0xAB) and waits for the flash to wake before it accepts requests. Each accepted request returns one 32-bit little-endian word. It sits between the SoC requesters and the top-level flash_* pins.

Parameters:
CLK_DIV, 2, SCK half-period in clk cycles (>=1); SCK = clk/(2*CLK_DIV)
WAKE_CYCLES, 48, clk cycles to hold csb high after 0xAB before leaving wake state (>=1)
CS_HIGH_CYCLES, 2, minimum clk cycles csb stays high between transactions (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-high reset
req0_valid  input  1  requester 0 read request
req0_addr  input  24  requester 0 byte address
req0_ready  output  1  one-cycle accept pulse for requester 0
req1_valid  input  1  requester 1 read request
req1_addr  input  24  requester 1 byte address
req1_ready  output  1  one-cycle accept pulse for requester 1
rsp_valid  output  1  one-cycle pulse: rsp_data valid
rsp_id  output  1  requester that owns rsp_data
rsp_data  output  32  read word; first byte received in [7:0]
busy  output  1  high whenever state != IDLE
flash_csb  output  1  SPI chip select, active low
flash_clk  output  1  SPI clock, mode 0, idles low
flash_io0  output  1  MOSI
flash_io1  input  1  MISO

Behaviour:
- Reset (async, any state): flash_csb=1, flash_clk=0, flash_io0=0, req*_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=1, last_grant=1, state=WAKE_CMD. Reset mid-transfer aborts immediately. No partial response is issued.
- States: WAKE_CMD -> WAKE_WAIT -> IDLE -> CMD -> ADDR -> DATA -> GAP -> IDLE.
- WAKE_CMD: csb low, shift 0xAB MSB-first (8 bits), then csb high.
- WAKE_WAIT: counts WAKE_CYCLES cycles with csb high, then enters IDLE.
- IDLE: busy=0.
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the requester != last_grant (round robin). After reset, req0 wins the first tie.
  - Grant cycle: reqN_ready=1 for exactly one cycle. Latch addr and id, update last_grant, go to CMD.
  - Requests arriving while busy are held by the requester (valid stays high) and are not acknowledged.
- Bit engine (CMD/ADDR/DATA):
  - csb drops on the first cycle of CMD.
  - MOSI is driven with flash_clk low and held CLK_DIV cycles before each rising edge.
  - flash_clk toggles every CLK_DIV cycles.
  - MISO is sampled on the clk cycle that raises flash_clk.
  - MOSI changes only on the cycle that lowers flash_clk.
- CMD shifts 0x03. ADDR shifts addr[23:0] MSB-first. DATA clocks 32 bits with MOSI=0.
- Byte assembly: bits are MSB-first within a byte. Byte k (k=0..3) lands in rsp_data[8k+7:8k].
- End of DATA:
  - After the final falling edge, flash_clk=0 and csb=1.
  - rsp_valid=1 for one cycle, with rsp_data and rsp_id stable from that cycle until the next rsp_valid.
  - Then go to GAP.
- GAP: csb high for CS_HIGH_CYCLES, then IDLE. The next grant therefore occurs >= CS_HIGH_CYCLES+1 cycles after rsp_valid.
- Bit count per read: 64 SCK periods (8+24+32). Latency from grant to rsp_valid = 128*CLK_DIV + 1 cycles.
- Address is not incremented or wrapped. The flash wraps internally at the top of the array; the block does not check this.
- There is no response backpressure; requesters must accept rsp_valid when their id is presented.

Test Plan:
- Reset release with CLK_DIV=2 -> 0xAB observed on io0 within 8 SCK, csb high for >=48 clk, req0_ready stays 0 until busy falls.
- req0 read at 0x100000 with model bytes 11 22 33 44 -> MOSI stream 03 10 00 00, rsp_valid once, rsp_id=0, rsp_data=0x44332211, latency 257 clk.
- req0 and req1 asserted together from IDLE, both held -> grants in order 0,1,0,1 and rsp_id sequence 0,1,0,1. Each transaction is separated by csb high >=2 clk.
- Only req1 valid, repeated 3 times -> three grants to req1, no starvation logic interfering.
- rst pulsed mid-ADDR phase -> csb=1 and flash_clk=0 asynchronously, no rsp_valid. Wake sequence repeats, then a fresh read returns correct data.
- CLK_DIV=1 build, read at 0x0000FC -> SCK period 2 clk, rsp_data matches model, latency 129 clk.
